// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
// PLL bring-up and recovery sequencer: drives the PLL reset, qualifies the
// synchronised lock, gates the downstream reset and tracks retries/losses.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] loss_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);
  localparam logic [7:0]       LOSS_MAX    = 8'hFF;

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             lock_meta;
  logic             lock_s;

  assign state = state_q;

  // Next-state, counter and timer decode; all decisions use lock_s only.
  always_comb begin
    state_nxt = state_q;
    retry_nxt = retry_count;
    loss_nxt  = loss_count;
    unique case (state_q)
      S_RESET_PLL: begin
        if (timer_q == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = S_STABLE;
        end else if (relock_req) begin
          state_nxt = S_RESET_PLL;
        end else if (timer_q == LOCK_LAST) begin
          retry_nxt = retry_count + 4'd1;
          state_nxt = (retry_nxt == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
        end else if (relock_req) begin
          state_nxt = S_RESET_PLL;
        end else if (timer_q == STABLE_LAST) begin
          state_nxt = S_RUN;
          retry_nxt = 4'd0;
        end
      end
      S_RUN: begin
        // A loss coinciding with a relock request still counts as a loss.
        if (!lock_s) begin
          state_nxt = S_RESET_PLL;
          if (loss_count != LOSS_MAX) loss_nxt = loss_count + 8'd1;
        end else if (relock_req) begin
          state_nxt = S_RESET_PLL;
        end
      end
      S_FAULT: begin
        if (relock_req) begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 4'd0;
        end
      end
      default: state_nxt = S_RESET_PLL;
    endcase

    if ((state_nxt == S_RUN) || (state_nxt == S_FAULT) || (state_nxt != state_q)) begin
      timer_nxt = '0;
    end else begin
      timer_nxt = timer_q + CNT_W'(1);
    end
  end

  // State, counters, lock synchroniser and outputs registered from next-state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state_q     <= S_RESET_PLL;
      timer_q     <= '0;
      retry_count <= 4'd0;
      loss_count  <= 8'd0;
      pll_rst     <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      lock_meta   <= pll_locked;
      lock_s      <= lock_meta;
      state_q     <= state_nxt;
      timer_q     <= timer_nxt;
      retry_count <= retry_nxt;
      loss_count  <= loss_nxt;
      pll_rst     <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      sys_reset_n <= (state_nxt == S_RUN);
      ready       <= (state_nxt == S_RUN);
      fault       <= (state_nxt == S_FAULT);
    end
  end

endmodule
